mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data and address width of all ports.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1: reset is synchronous and active-high.
REQ-004 SHALL have port m0_req_i  input  1: CPU port request, held until granted.
REQ-005 SHALL have port m0_we_i  input  1: CPU request is a write (1) or a read (0).
REQ-006 SHALL have port m0_addr_i  input  WIDTH: CPU byte address.
REQ-007 SHALL have port m0_wdata_i  input  WIDTH: CPU write data.
REQ-008 SHALL have port m0_gnt_o  output  1: CPU request accepted this cycle.
REQ-009 SHALL have port m0_rvalid_o  output  1: CPU read data valid this cycle.
REQ-010 SHALL have port m0_rdata_o  output  WIDTH: CPU read data.
REQ-011 SHALL have ports m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: the DMA/blitter port, with the same directions, widths and meanings as REQ-004..010.
REQ-012 SHALL have port memread_o  output  1: read strobe to the memory block.
REQ-013 SHALL have port memwrite_o  output  1: write strobe to the memory block.
REQ-014 SHALL have port memaddr_o  output  WIDTH: address to the memory block.
REQ-015 SHALL have port memwdata_o  output  WIDTH: write data to the memory block.
REQ-016 SHALL have port memrdata_i  input  WIDTH: memory read data, valid exactly one cycle after memread_o.

Function
REQ-017 SHALL grant at most one master per cycle; a grant is combinational from the current-cycle req and arbiter state.
REQ-018 SHALL drive memread_o = granted & ~we and memwrite_o = granted & we, with addr and wdata muxed from the granted master in the same cycle; with no grant, strobes are 0 and addr/wdata are 0.
REQ-019 SHALL arbitrate round-robin with a 1-bit priority pointer: with both masters requesting, grant the master the pointer names; after any grant, point the pointer at the other master.
REQ-020 SHALL grant a lone requester regardless of the pointer, unless a bubble is active (REQ-022).
REQ-021 SHALL register a read-pending flag and an owner bit on each read grant; in the next cycle, assert rvalid of that owner only, with rdata = memrdata_i. rdata of the non-owner SHALL be 0.
REQ-022 SHALL insert one bubble cycle after every write grant: no grant of any kind in the cycle that follows. The memory output mux is not valid for a read issued directly after a write.
REQ-023 SHALL allow back-to-back read grants, one per cycle, to either master, with rvalid returned in grant order.
REQ-024 SHALL keep a 2-state FSM: ARB (grants allowed) -> BUBBLE on a write grant; BUBBLE -> ARB unconditionally after 1 cycle.
REQ-025 SHALL not update the pointer in BUBBLE or on cycles with no grant.
REQ-026 SHALL keep a 16-bit saturating wait counter per master: it increments while req is high without a grant and clears on grant. At 0xFFFF the waiting master SHALL win the next arbitration regardless of the pointer; if both counters are saturated, m0 wins.

Reset
REQ-027 SHALL, on rst, set FSM = ARB, pointer = m0, read-pending = 0, both wait counters = 0.
REQ-028 SHALL, in any cycle with rst high, drive all gnt, rvalid and mem strobes to 0; a read granted in the cycle before rst asserts SHALL NOT return rvalid.

Verification
REQ-029 SHALL pass: m0 reads addr 0x1000 alone -> m0_gnt=1, memread_o=1, memaddr_o=0x1000 at cycle t; m0_rvalid=1 with memrdata_i at t+1; m1_rvalid=0.
REQ-030 SHALL pass: both masters hold read requests for 4 cycles after reset -> grants m0,m1,m0,m1, and rvalid follows with the same owners one cycle later.
REQ-031 SHALL pass: m1 writes 0xFFF00010 data 0xABC while m0 reads and m1 wins -> memwrite_o=1 at t; no grant at t+1 (BUBBLE); m0 granted at t+2.
REQ-032 SHALL pass: m1 wait counter forced to 0xFFFF with pointer=m0 and both requesting -> m1 granted; its counter clears to 0.
REQ-033 SHALL pass: rst asserted the cycle after a read grant -> no rvalid, pointer=m0, FSM=ARB on the cycle after rst deasserts.
REQ-034 SHALL pass: no requests for 10 cycles -> memread_o=memwrite_o=0 and memaddr_o=0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin memory arbiter (CPU port m0, DMA/blitter port m1).
// A write grant is always followed by one dead cycle; reads return data one cycle after grant.
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req_i,
    input  logic             m0_we_i,
    input  logic [WIDTH-1:0] m0_addr_i,
    input  logic [WIDTH-1:0] m0_wdata_i,
    output logic             m0_gnt_o,
    output logic             m0_rvalid_o,
    output logic [WIDTH-1:0] m0_rdata_o,
    input  logic             m1_req_i,
    input  logic             m1_we_i,
    input  logic [WIDTH-1:0] m1_addr_i,
    input  logic [WIDTH-1:0] m1_wdata_i,
    output logic             m1_gnt_o,
    output logic             m1_rvalid_o,
    output logic [WIDTH-1:0] m1_rdata_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic [WIDTH-1:0] memaddr_o,
    output logic [WIDTH-1:0] memwdata_o,
    input  logic [WIDTH-1:0] memrdata_i
);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        BUBBLE = 1'b1
    } arb_state_t;

    arb_state_t  state_r;
    arb_state_t  state_nxt_s;
    logic        ptr_r;        // 0 = m0 has priority, 1 = m1 has priority
    logic        rd_pend_r;
    logic        rd_owner_r;   // 0 = m0, 1 = m1
    logic [15:0] wait0_r;
    logic [15:0] wait1_r;
    logic        gnt0_s;
    logic        gnt1_s;
    logic        sat0_s;
    logic        sat1_s;
    logic        wr_gnt_s;
    logic        rd_gnt_s;
    logic        rvalid0_s;
    logic        rvalid1_s;

    // Saturating starvation counter: clears on grant, counts while left waiting.
    function automatic logic [15:0] wait_next(input logic req, input logic gnt,
                                              input logic [15:0] cnt);
        logic [15:0] res;
        if (gnt) begin
            res = 16'h0000;
        end else if (req && (cnt != 16'hFFFF)) begin
            res = cnt + 16'h0001;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    assign sat0_s = (wait0_r == 16'hFFFF);
    assign sat1_s = (wait1_r == 16'hFFFF);

    // Grant decision and next FSM state; nothing is granted in reset or in the bubble.
    always_comb begin
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        state_nxt_s = state_r;
        if (rst) begin
            state_nxt_s = ARB;
        end else begin
            case (state_r)
                ARB: begin
                    if (m0_req_i && m1_req_i) begin
                        // A starved master overrides the pointer; m0 breaks a double tie.
                        if (sat0_s) begin
                            gnt0_s = 1'b1;
                        end else if (sat1_s) begin
                            gnt1_s = 1'b1;
                        end else if (ptr_r == 1'b0) begin
                            gnt0_s = 1'b1;
                        end else begin
                            gnt1_s = 1'b1;
                        end
                    end else if (m0_req_i) begin
                        gnt0_s = 1'b1;
                    end else if (m1_req_i) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b0;
                        gnt1_s = 1'b0;
                    end
                    if ((gnt0_s && m0_we_i) || (gnt1_s && m1_we_i)) begin
                        state_nxt_s = BUBBLE;
                    end else begin
                        state_nxt_s = ARB;
                    end
                end
                BUBBLE: begin
                    state_nxt_s = ARB;
                end
                default: begin
                    state_nxt_s = ARB;
                end
            endcase
        end
    end

    assign wr_gnt_s = (gnt0_s && m0_we_i) || (gnt1_s && m1_we_i);
    assign rd_gnt_s = (gnt0_s && !m0_we_i) || (gnt1_s && !m1_we_i);

    // Memory-side mux driven from the granted master; idle bus is all zeros.
    always_comb begin
        memread_o  = 1'b0;
        memwrite_o = 1'b0;
        memaddr_o  = {WIDTH{1'b0}};
        memwdata_o = {WIDTH{1'b0}};
        if (gnt0_s) begin
            memread_o  = !m0_we_i;
            memwrite_o = m0_we_i;
            memaddr_o  = m0_addr_i;
            memwdata_o = m0_wdata_i;
        end else if (gnt1_s) begin
            memread_o  = !m1_we_i;
            memwrite_o = m1_we_i;
            memaddr_o  = m1_addr_i;
            memwdata_o = m1_wdata_i;
        end else begin
            memread_o  = 1'b0;
            memwrite_o = 1'b0;
        end
    end

    assign m0_gnt_o = gnt0_s;
    assign m1_gnt_o = gnt1_s;

    // rvalid is suppressed during reset so a read issued just before reset is dropped.
    assign rvalid0_s   = !rst && rd_pend_r && !rd_owner_r;
    assign rvalid1_s   = !rst && rd_pend_r && rd_owner_r;
    assign m0_rvalid_o = rvalid0_s;
    assign m1_rvalid_o = rvalid1_s;
    assign m0_rdata_o  = rvalid0_s ? memrdata_i : {WIDTH{1'b0}};
    assign m1_rdata_o  = rvalid1_s ? memrdata_i : {WIDTH{1'b0}};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Priority pointer moves to the other master only on an actual grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (gnt0_s) begin
            ptr_r <= 1'b1;
        end else if (gnt1_s) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Read-return tracking: one outstanding read, owner recorded at grant time.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= 1'b0;
        end else begin
            rd_pend_r  <= rd_gnt_s;
            rd_owner_r <= gnt1_s;
        end
    end

    // Per-master starvation counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait0_r <= 16'h0000;
            wait1_r <= 16'h0000;
        end else begin
            wait0_r <= wait_next(m0_req_i, gnt0_s, wait0_r);
            wait1_r <= wait_next(m1_req_i, gnt1_s, wait1_r);
        end
    end

    mem_arbiter_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .gnt0     (gnt0_s),
        .gnt1     (gnt1_s),
        .wr_gnt   (wr_gnt_s),
        .memread  (memread_o),
        .memwrite (memwrite_o),
        .rvalid0  (rvalid0_s),
        .rvalid1  (rvalid1_s)
    );

endmodule

// Protocol invariants of the arbiter, kept apart from the datapath.
module mem_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic gnt0,
    input logic gnt1,
    input logic wr_gnt,
    input logic memread,
    input logic memwrite,
    input logic rvalid0,
    input logic rvalid1
);

    a_one_grant: assert property (@(posedge clk) !(gnt0 && gnt1));
    a_one_strobe: assert property (@(posedge clk) !(memread && memwrite));
    a_one_rvalid: assert property (@(posedge clk) !(rvalid0 && rvalid1));
    a_bubble: assert property (@(posedge clk) disable iff (rst)
                               wr_gnt |=> !(gnt0 || gnt1));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, round robin, write bubble,
// starvation override, reset during read return and idle bus.
module tb_mem_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         m0_req, m0_we, m1_req, m1_we;
    logic [W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic         m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic         memread, memwrite;
    logic [W-1:0] memaddr, memwdata;
    logic [W-1:0] memrdata = 32'h0000_0000;
    int           n_cmp = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    // Memory model: read data = address + 5, one cycle after the read strobe.
    always @(posedge clk) begin
        if (memread) memrdata <= memaddr + 32'h0000_0005;
        else         memrdata <= 32'hBAD0_BAD0;
    end

    mem_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .memread_o(memread), .memwrite_o(memwrite), .memaddr_o(memaddr),
        .memwdata_o(memwdata), .memrdata_i(memrdata)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b1;
        m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
        m0_wdata = 32'h0000_0000; m1_wdata = 32'h0000_0011;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
            n_cmp++; if ({memread, memwrite} !== 2'b00) begin n_fail++; $display("FAIL rst_strobe: got %b want 00", {memread, memwrite}); end
            n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        end
        m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_1000; #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL rd_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        n_cmp++; if ({memread, memwrite} !== 2'b10) begin n_fail++; $display("FAIL rd_strobe: got %b want 10", {memread, memwrite}); end
        n_cmp++; if (memaddr !== 32'h0000_1000) begin n_fail++; $display("FAIL rd_addr: got %h want 00001000", memaddr); end
        @(negedge clk);
        m0_req = 1'b0; #1;
        n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL rd_rvalid: got %b want 10", {m0_rvalid, m1_rvalid}); end
        n_cmp++; if (m0_rdata !== 32'h0000_1005) begin n_fail++; $display("FAIL rd_rdata: got %h want 00001005", m0_rdata); end
        n_cmp++; if (m1_rdata !== 32'h0000_0000) begin n_fail++; $display("FAIL rd_m1_rdata: got %h want 0", m1_rdata); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [W-1:0] exp_a;
        do_reset();
        m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h0000_2000; m1_addr = 32'h0000_3000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            m0_req = (c < 4); m1_req = (c < 4); #1;
            if (c < 4) begin
                exp_a = exp_g[c][1] ? 32'h0000_2000 : 32'h0000_3000;
                n_cmp++; if ({m0_gnt, m1_gnt} !== exp_g[c]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, {m0_gnt, m1_gnt}, exp_g[c]); end
                n_cmp++; if (memaddr !== exp_a) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", c, memaddr, exp_a); end
            end
            if (c > 0) begin
                exp_a = exp_g[c-1][1] ? 32'h0000_2005 : 32'h0000_3005;
                n_cmp++; if ({m0_rvalid, m1_rvalid} !== exp_g[c-1]) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", c, {m0_rvalid, m1_rvalid}, exp_g[c-1]); end
                n_cmp++; if ((m0_rdata | m1_rdata) !== exp_a) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", c, m0_rdata | m1_rdata, exp_a); end
            end
        end
    endtask

    task automatic test_write_bubble();
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_7000; #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL wb_pre_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        @(negedge clk);
        m0_addr = 32'h0000_4000;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hFFF0_0010; m1_wdata = 32'h0000_0ABC; #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL wb_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
        n_cmp++; if ({memread, memwrite} !== 2'b01) begin n_fail++; $display("FAIL wb_strobe: got %b want 01", {memread, memwrite}); end
        n_cmp++; if ({memaddr, memwdata} !== {32'hFFF0_0010, 32'h0000_0ABC}) begin n_fail++; $display("FAIL wb_addr_data: got %h/%h want fff00010/00000abc", memaddr, memwdata); end
        n_cmp++; if (m0_rdata !== 32'h0000_7005) begin n_fail++; $display("FAIL wb_pre_rdata: got %h want 00007005", m0_rdata); end
        @(negedge clk);
        m1_req = 1'b0; m1_we = 1'b0; #1;
        n_cmp++; if ({m0_gnt, m1_gnt, memread, memwrite} !== 4'b0000) begin n_fail++; $display("FAIL wb_bubble: got %b want 0000", {m0_gnt, m1_gnt, memread, memwrite}); end
        n_cmp++; if (memaddr !== 32'h0000_0000) begin n_fail++; $display("FAIL wb_bubble_addr: got %h want 0", memaddr); end
        @(negedge clk); #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL wb_after_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        n_cmp++; if (memaddr !== 32'h0000_4000) begin n_fail++; $display("FAIL wb_after_addr: got %h want 00004000", memaddr); end
        @(negedge clk);
        m0_req = 1'b0; #1;
        n_cmp++; if (m0_rdata !== 32'h0000_4005) begin n_fail++; $display("FAIL wb_after_rdata: got %h want 00004005", m0_rdata); end
    endtask

    task automatic test_starvation();
        do_reset();
        @(negedge clk);
        force dut.wait1_r = 16'hFFFF;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_5000;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_6000; #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL sat_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
        n_cmp++; if (memaddr !== 32'h0000_6000) begin n_fail++; $display("FAIL sat_addr: got %h want 00006000", memaddr); end
        #3;
        release dut.wait1_r;
        @(negedge clk);
        m1_req = 1'b0; #1;
        n_cmp++; if (dut.wait1_r !== 16'h0000) begin n_fail++; $display("FAIL sat_clear: got %h want 0000", dut.wait1_r); end
        n_cmp++; if (m1_rdata !== 32'h0000_6005) begin n_fail++; $display("FAIL sat_rdata: got %h want 00006005", m1_rdata); end
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL sat_next_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        @(negedge clk);
        m0_req = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_8000; #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL rk_pre_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
        @(negedge clk);
        m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_9000; #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL rk_lone_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        @(negedge clk);
        rst = 1'b1; m1_req = 1'b1; #1;
        n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rk_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        n_cmp++; if ({m0_gnt, m1_gnt, memread, memwrite} !== 4'b0000) begin n_fail++; $display("FAIL rk_gnt: got %b want 0000", {m0_gnt, m1_gnt, memread, memwrite}); end
        @(negedge clk);
        rst = 1'b0; #1;
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL rk_after_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rk_after_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_idle();
        m0_addr = 32'hFFFF_FFFF; m1_addr = 32'h1234_5678;
        m0_wdata = 32'hCAFE_F00D; m1_wdata = 32'h8765_4321;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            m0_req = 1'b0; m1_req = 1'b0; #1;
            n_cmp++; if ({memread, memwrite, memaddr, memwdata} !== {2'b00, 32'h0000_0000, 32'h0000_0000}) begin
                n_fail++; $display("FAIL idle[%0d]: got %b%b %h %h want 00 0 0", c, memread, memwrite, memaddr, memwdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_bubble();
        test_starvation();
        test_reset_mid_read();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
